// File: rtl/shift_pkg.sv
// Shared shift-datapath types: mode encoding, operand width and command bundle.
package shift_pkg;

    localparam int unsigned SHIFT_W = 4;

    typedef enum logic [2:0] {
        LSR = 3'b000,
        LSL = 3'b001,
        ASR = 3'b010,
        ASL = 3'b011,
        ROR = 3'b100,
        ROL = 3'b101
    } shift_mode_e;

    // Mode is kept as raw bits so undefined codes (3'b11x) pass through unchanged.
    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic [1:0]         amt;
        logic [2:0]         mode;
    } shift_cmd_t;

endpackage

// File: rtl/funnel_shifter.sv
// Combinational 4-bit funnel shifter: logical, arithmetic and rotate shifts by 0..3.
module funnel_shifter
    import shift_pkg::*;
(
    input  shift_cmd_t         cmd_i,
    output logic [SHIFT_W-1:0] result_o
);

    logic [SHIFT_W-1:0]   fill;
    logic                 shift_right;
    logic [2*SHIFT_W-1:0] funnel;

    always_comb begin
        fill        = '0;
        shift_right = 1'b1;
        funnel      = '0;
        case (cmd_i.mode)
            LSR:     shift_right = 1'b1;
            LSL,
            ASL:     shift_right = 1'b0;
            ASR:     fill = {SHIFT_W{cmd_i.data[SHIFT_W-1]}};
            // ROR, ROL and the unused 3'b11x codes all rotate; bit 0 picks direction.
            default: begin
                fill        = cmd_i.data;
                shift_right = ~cmd_i.mode[0];
            end
        endcase

        if (shift_right) begin
            funnel   = {fill, cmd_i.data} >> cmd_i.amt;
            result_o = funnel[SHIFT_W-1:0];
        end else begin
            funnel   = {cmd_i.data, fill} << cmd_i.amt;
            result_o = funnel[2*SHIFT_W-1:SHIFT_W];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above the pointer, with wrap.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IdW-1:0] idx_o
);

    logic        found;
    int unsigned k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr_i) + i) % N;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IdW'(k);
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one funnel shifter, with a single-entry response slot.
// Optional SHIFT_ARB_PERF_EN adds a saturating 16-bit backpressure stall counter.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [4*NUM_REQ-1:0]   req_data_i,
    input  logic [2*NUM_REQ-1:0]   req_amt_i,
    input  logic [3*NUM_REQ-1:0]   req_mode_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [SHIFT_W-1:0]     rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o
`ifdef SHIFT_ARB_PERF_EN
    ,
    output logic [15:0]            stall_cnt_o
`endif
);

    localparam logic StEmpty = 1'b0;
    localparam logic StFull  = 1'b1;

    logic               state_q;
    logic [ID_W-1:0]    rr_q;
    logic [SHIFT_W-1:0] data_q;
    logic [ID_W-1:0]    id_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    rr_next;
    logic               slot_free;
    logic               accept;
    shift_cmd_t         cmd;
    logic [SHIFT_W-1:0] result;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IdW (ID_W)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        slot_free   = (state_q == StEmpty) || rsp_ready_i;
        req_ready_o = (slot_free && rst_ni) ? gnt : '0;
        accept      = |(req_valid_i & req_ready_o);
        rr_next     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cmd.data    = req_data_i[gnt_idx*SHIFT_W +: SHIFT_W];
        cmd.amt     = req_amt_i[gnt_idx*2 +: 2];
        cmd.mode    = req_mode_i[gnt_idx*3 +: 3];
    end

    funnel_shifter u_funnel_shifter (
        .cmd_i    (cmd),
        .result_o (result)
    );

    // An accept while FULL overwrites the draining response in the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            rr_q    <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else if (accept) begin
            state_q <= StFull;
            rr_q    <= rr_next;
            data_q  <= result;
            id_q    <= gnt_idx;
        end else if (state_q == StFull && rsp_ready_i) begin
            state_q <= StEmpty;
        end
    end

    assign rsp_valid_o = state_q;
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;

`ifdef SHIFT_ARB_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (state_q == StFull && !rsp_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: shifts, round-robin order, backpressure and reset.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_data;
    logic [2*N-1:0] req_amt;
    logic [3*N-1:0] req_mode;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [3:0]     rsp_data;
    logic [1:0]     rsp_id;
`ifdef SHIFT_ARB_PERF_EN
    logic [15:0]    stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    shift_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_amt_i   (req_amt),
        .req_mode_i  (req_mode),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id)
`ifdef SHIFT_ARB_PERF_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic [3:0] d, input logic [1:0] a,
                           input logic [2:0] m);
        req_data[4*k +: 4] = d;
        req_amt[2*k +: 2]  = a;
        req_mode[3*k +: 3] = m;
    endtask

    logic [3:0] rr_exp [N];

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_amt   = '0;
        req_mode  = '0;
        rsp_ready = 1'b1;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_data", 32'(rsp_data), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);
        check("rst_rr", 32'(dut.rr_q), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Requester 0: 0011 LSL 1 -> 0110
        set_cmd(0, 4'b0011, 2'd1, LSL);
        req_valid = 4'b0001;
        #1 check("lsl_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        check("lsl_valid", 32'(rsp_valid), 32'h1);
        check("lsl_data", 32'(rsp_data), 32'h6);
        check("lsl_id", 32'(rsp_id), 32'h0);

        // Requester 2: 1000 ASR 2 -> 1110
        set_cmd(2, 4'b1000, 2'd2, ASR);
        req_valid = 4'b0100;
        #1 check("asr_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check("asr_data", 32'(rsp_data), 32'hE);
        check("asr_id", 32'(rsp_id), 32'h2);

        // Requester 1: 1001 ROR 1 -> 1100 (pointer at 3 wraps to 1)
        set_cmd(1, 4'b1001, 2'd1, ROR);
        req_valid = 4'b0010;
        #1 check("ror_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        check("ror_data", 32'(rsp_data), 32'hC);
        check("ror_id", 32'(rsp_id), 32'h1);

        // Drain with nothing pending: slot empties, payload kept
        step();
        check("drain_valid", 32'(rsp_valid), 32'h0);
        check("drain_data", 32'(rsp_data), 32'hC);
        check("drain_id", 32'(rsp_id), 32'h1);

        // Requester 3: 0101 ROL 3 -> 1010, pointer wraps to 0
        set_cmd(3, 4'b0101, 2'd3, ROL);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        check("rol_data", 32'(rsp_data), 32'hA);
        check("rol_id", 32'(rsp_id), 32'h3);
        check("rol_rr", 32'(dut.rr_q), 32'h0);
        step();

        // All valid, ROL 1 each: grant order 0,1,2,3,0
        set_cmd(0, 4'b0001, 2'd1, ROL);
        set_cmd(1, 4'b0010, 2'd1, ROL);
        set_cmd(2, 4'b0100, 2'd1, ROL);
        set_cmd(3, 4'b1000, 2'd1, ROL);
        rr_exp[0] = 4'b0010;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("rr_ready%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            step();
            check($sformatf("rr_id%0d", i), 32'(rsp_id), 32'(i % 4));
            check($sformatf("rr_data%0d", i), 32'(rsp_data), 32'(rr_exp[i % 4]));
            check($sformatf("rr_valid%0d", i), 32'(rsp_valid), 32'h1);
        end

        // Backpressure for 3 cycles: response held, no grants
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
            step();
            check($sformatf("bp_data%0d", i), 32'(rsp_data), 32'h2);
            check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'h0);
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'h1);
        end
`ifdef SHIFT_ARB_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
        // Release: drain and accept requester 1 in the same edge
        rsp_ready = 1'b1;
        #1 check("rel_ready", 32'(req_ready), 32'h2);
        step();
        check("rel_valid", 32'(rsp_valid), 32'h1);
        check("rel_id", 32'(rsp_id), 32'h1);
        check("rel_data", 32'(rsp_data), 32'h4);

        // Reset while FULL discards the response and the pointer
        rst_n = 1'b0;
        #1 check("mrst_ready", 32'(req_ready), 32'h0);
        step();
        check("mrst_valid", 32'(rsp_valid), 32'h0);
        check("mrst_rr", 32'(dut.rr_q), 32'h0);
        check("mrst_data", 32'(rsp_data), 32'h0);
        rst_n     = 1'b1;
        req_valid = 4'b1110;
        #1 check("post_ready", 32'(req_ready), 32'h2);
        step();
        check("post_id", 32'(rsp_id), 32'h1);
        check("post_data", 32'(rsp_data), 32'h4);

        // Undefined mode 3'b110 rotates right: 1011 -> 1101
        set_cmd(0, 4'b1011, 2'd1, 3'b110);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        check("m110_data", 32'(rsp_data), 32'hD);
        check("m110_id", 32'(rsp_id), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and response sequencer that shares one 4-bit funnel shifter datapath among `NUM_REQ` requesters. Each requester presents a shift command (data, amount, mode) over a valid/ready handshake. The block grants one requester per cycle, drives the shared `funnel_shifter` combinationally, and registers the result into a single-entry response slot. The response carries the requester ID and is held under downstream backpressure.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: requester ID width; derived, not overridden.
- `clk_i`  in  1: single clock, rising edge.
- `rst_ni`  in  1: reset is synchronous and active-low.
- `req_valid_i`  in  NUM_REQ: per-requester command valid.
- `req_ready_o`  out  NUM_REQ: per-requester accept; one-hot or zero.
- `req_data_i`  in  4*NUM_REQ: operand; requester k uses bits [4k+3:4k].
- `req_amt_i`  in  2*NUM_REQ: shift amount, 0..3.
- `req_mode_i`  in  3*NUM_REQ: shift mode, encoded exactly as the funnel shifter encodes it.
- `rsp_valid_o`  out  1: response slot full.
- `rsp_ready_i`  in  1: downstream accepts the response.
- `rsp_data_o`  out  4: shifted result.
- `rsp_id_o`  out  ID_W: index of the requester that produced the response.

## Operation
- Response slot FSM has two states:
  - EMPTY: `rsp_valid_o`=0.
  - FULL: `rsp_valid_o`=1.
- `slot_free` = EMPTY, or (FULL and `rsp_ready_i`).
- Arbitration is round-robin over `req_valid_i`, starting at pointer `rr_q` (ID_W bits) and searching upward with wrap.
- `req_ready_o[g]`=1 only for the winner g, only when `slot_free`=1 and `rst_ni`=1. All other bits are 0.
- An accept is `req_valid_i[g] & req_ready_o[g]`. On an accept:
  - The winner's data, amt and mode drive the shifter.
  - The result goes to `rsp_data_o` and g goes to `rsp_id_o`.
  - The FSM moves to FULL, or stays FULL.
  - `rr_q` becomes g+1 mod NUM_REQ.
- FULL with `rsp_ready_i`=1 and no accept: FSM moves to EMPTY. `rsp_data_o` and `rsp_id_o` keep their last values.
- FULL with `rsp_ready_i`=0: `rsp_data_o` and `rsp_id_o` are held stable. `req_ready_o` is all 0.
- Simultaneous drain and accept while FULL: the old response is consumed and the new one is loaded in the same edge, with no bubble.
- No valid requests: `rr_q` is unchanged.
- The arbiter applies no mode or amount checks. Every mode code is forwarded unchanged, and code 3'b11x behaves as 3'b10x (rotate).
- Requesters must hold their command stable while valid and not ready. A requester may deassert valid without penalty.

## Timing
- Reset values: `rsp_valid_o`=0, `rsp_data_o`=4'h0, `rsp_id_o`=0, `rr_q`=0. `req_ready_o`=0 while `rst_ni`=0.
- Reset mid-operation: a pending response is discarded, with no handshake to downstream.
- Latency is 1 cycle: a command accepted at edge n is visible on `rsp_*` after edge n.
- Throughput is one command per cycle while `rsp_ready_i`=1.
- `req_ready_o` depends combinationally on `req_valid_i`, `rsp_ready_i` and state.
- `rsp_valid_o`, `rsp_data_o` and `rsp_id_o` are driven from registers only.
- Fairness: a requester held valid is granted within NUM_REQ accepts.

## Configuration
- `SHIFT_ARB_PERF_EN` defined:
  - Adds output `stall_cnt_o` (16 bits).
  - It counts cycles with `rsp_valid_o`=1 and `rsp_ready_i`=0.
  - It saturates at 16'hFFFF and resets to 0.
- `SHIFT_ARB_PERF_EN` not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `shift_pkg` holds:
  - the `shift_mode_e` enum (LSR=3'b000, LSL=3'b001, ASR=3'b010, ASL=3'b011, ROR=3'b100, ROL=3'b101);
  - constant `SHIFT_W`=4;
  - `shift_cmd_t` struct {data, amt, mode}.
- Sub-module `rr_arbiter` (parameter N): inputs are the request vector and pointer; outputs are the one-hot grant and the encoded index.
- The shared datapath is one `funnel_shifter` instance, fed by the grant-selected command.

## Test plan
- Single requester 0: data=4'b0011, amt=1, mode LSL -> one cycle later `rsp_data_o`=4'b0110, `rsp_id_o`=0.
- Requester 2: data=4'b1000, amt=2, mode ASR -> `rsp_data_o`=4'b1110, `rsp_id_o`=2.
- Requester 1: data=4'b1001, amt=1, mode ROR -> `rsp_data_o`=4'b1100.
- All 4 requesters valid continuously, `rsp_ready_i`=1 -> grant order 0,1,2,3,0 on consecutive cycles, and each `rsp_id_o` matches its grant.
- Response FULL, `rsp_ready_i`=0 for 3 cycles -> `rsp_data_o` stable, `req_ready_o`=0; if `SHIFT_ARB_PERF_EN` is defined, `stall_cnt_o`=3. On release, the drain and the next accept happen in the same cycle.
- `rst_ni`=0 while FULL -> next cycle `rsp_valid_o`=0 and `rr_q`=0; the first grant after reset goes to the lowest valid index.
